// File: rtl/memif_pkg.sv
// -----------------------------------------------------------------------------
// memif_pkg
// Shared definitions for the memif age arbiter slice: burst-length width,
// direction encodings, age counter width and the arbiter FSM state type.
// -----------------------------------------------------------------------------
package memif_pkg;

    // Burst length field width (beats - 1).
    localparam int unsigned MEMIF_LEN_W = 7;

    // Direction encodings on the rw lines.
    localparam logic MEMIF_RD = 1'b1;
    localparam logic MEMIF_WR = 1'b0;

    // Age counters cover the full 1..255 AGE_MAX range.
    localparam int unsigned AGE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } memif_state_e;

endpackage

// File: rtl/memif_age_arb_if.sv
// -----------------------------------------------------------------------------
// memif_age_arb_if
// Bundles the N requester-side memif ports (d_*) and the single upstream
// memif master port (u_*) around the age arbiter.
//   slave  : arbiter view (takes d_* commands, issues u_* commands)
//   master : environment view (requesters plus upstream controller)
// Per-port fields are packed, port i at [i*W +: W].
// -----------------------------------------------------------------------------
interface memif_age_arb_if
    import memif_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 16
) ();

    // Requester side
    logic [N*AW-1:0]          d_addr;
    logic [N*MEMIF_LEN_W-1:0] d_len;
    logic [N-1:0]             d_rw;
    logic [N-1:0]             d_valid;
    logic [N-1:0]             d_ready;
    logic [N*DW-1:0]          d_wdata;
    logic [N-1:0]             d_wack;
    logic [N-1:0]             d_wlast;
    logic [N*DW-1:0]          d_rdata;
    logic [N-1:0]             d_rstb;
    logic [N-1:0]             d_rlast;

    // Upstream side
    logic [AW-1:0]            u_addr;
    logic [MEMIF_LEN_W-1:0]   u_len;
    logic                     u_rw;
    logic                     u_valid;
    logic                     u_ready;
    logic [DW-1:0]            u_wdata;
    logic                     u_wack;
    logic                     u_wlast;
    logic [DW-1:0]            u_rdata;
    logic                     u_rstb;
    logic                     u_rlast;

    modport slave (
        input  d_addr, d_len, d_rw, d_valid, d_wdata,
        output d_ready, d_wack, d_wlast, d_rdata, d_rstb, d_rlast,
        output u_addr, u_len, u_rw, u_valid, u_wdata,
        input  u_ready, u_wack, u_wlast, u_rdata, u_rstb, u_rlast
    );

    modport master (
        output d_addr, d_len, d_rw, d_valid, d_wdata,
        input  d_ready, d_wack, d_wlast, d_rdata, d_rstb, d_rlast,
        input  u_addr, u_len, u_rw, u_valid, u_wdata,
        output u_ready, u_wack, u_wlast, u_rdata, u_rstb, u_rlast
    );

endinterface

// File: rtl/memif_age_cnt.sv
// -----------------------------------------------------------------------------
// memif_age_cnt
// Saturating wait counter for one requester port.
//   clk, rst : clock, synchronous active-high reset
//   inc      : port is waiting this cycle
//   clr      : port's command accepted this cycle (wins over inc)
//   age      : registered wait count, saturates at AGE_MAX
// -----------------------------------------------------------------------------
module memif_age_cnt
    import memif_pkg::*;
#(
    parameter int unsigned AGE_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [AGE_W-1:0] age
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            age <= '0;
        end else if (inc && (age != AGE_W'(AGE_MAX))) begin
            age <= age + AGE_W'(1);
        end
    end

endmodule

// File: rtl/memif_age_arb.sv
// -----------------------------------------------------------------------------
// memif_age_arb
// N-port fixed-priority arbiter with per-port aging in front of a single
// upstream memif master. The grant is held from command acceptance to the
// last data beat.
//   clk, rst : clock, synchronous active-high reset
//   bus      : memif_age_arb_if.slave -- d_* requester ports, u_* upstream
// Parameters: N ports, AW/DW address/data width, WRITE_DISABLE per-port
// read-only mask, AGE_MAX wait cycles before a port is promoted.
// -----------------------------------------------------------------------------
module memif_age_arb
    import memif_pkg::*;
#(
    parameter int unsigned  N             = 3,
    parameter int unsigned  AW            = 32,
    parameter int unsigned  DW            = 16,
    parameter logic [N-1:0] WRITE_DISABLE = '0,
    parameter int unsigned  AGE_MAX       = 15
) (
    input  logic            clk,
    input  logic            rst,
    memif_age_arb_if.slave  bus
);

    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

    memif_state_e           state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [SEL_W-1:0]       pick, aged_idx, valid_idx;
    logic                   aged_hit;
    logic [AGE_W-1:0]       age [N];

    logic [AW-1:0]          cmd_addr;
    logic [MEMIF_LEN_W-1:0] cmd_len;
    logic                   cmd_rw;
    logic [DW-1:0]          cmd_wdata;
    logic                   cmd_wd;

    logic [N-1:0]           ready_vec, wack_vec, wlast_vec, rstb_vec, rlast_vec;

    // Per-port wait counters; acceptance clears, waiting increments.
    for (genvar i = 0; i < N; i++) begin : g_age
        memif_age_cnt #(
            .AGE_MAX(AGE_MAX)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (bus.d_valid[i] & ~ready_vec[i]),
            .clr (ready_vec[i]),
            .age (age[i])
        );
    end

    // Selection: lowest-index saturated requester first, else lowest-index
    // requester. Scanning downwards lets the lowest index be the last write.
    always_comb begin
        aged_hit  = 1'b0;
        aged_idx  = '0;
        valid_idx = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (bus.d_valid[i-1]) begin
                valid_idx = SEL_W'(i - 1);
                if (age[i-1] == AGE_W'(AGE_MAX)) begin
                    aged_hit = 1'b1;
                    aged_idx = SEL_W'(i - 1);
                end
            end
        end
        pick = aged_hit ? aged_idx : valid_idx;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.d_valid) begin
                    sel_d   = pick;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (bus.u_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bus.u_rlast || bus.u_wlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command fields of the selected port
    always_comb begin
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_rw    = MEMIF_RD;
        cmd_wdata = '0;
        cmd_wd    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_q == SEL_W'(i)) begin
                cmd_addr  = bus.d_addr[i*AW +: AW];
                cmd_len   = bus.d_len[i*MEMIF_LEN_W +: MEMIF_LEN_W];
                cmd_rw    = bus.d_rw[i];
                cmd_wdata = bus.d_wdata[i*DW +: DW];
                cmd_wd    = WRITE_DISABLE[i];
            end
        end
    end

    // Output logic: handshakes routed to the selected port only
    always_comb begin
        ready_vec = '0;
        wack_vec  = '0;
        wlast_vec = '0;
        rstb_vec  = '0;
        rlast_vec = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_q == SEL_W'(i)) begin
                ready_vec[i] = (state_q == ST_CMD) && bus.u_ready;
                rstb_vec[i]  = (state_q == ST_DATA) && bus.u_rstb;
                rlast_vec[i] = (state_q == ST_DATA) && bus.u_rlast;
                wack_vec[i]  = (state_q == ST_DATA) && bus.u_wack  && !WRITE_DISABLE[i];
                wlast_vec[i] = (state_q == ST_DATA) && bus.u_wlast && !WRITE_DISABLE[i];
            end
        end
    end

    assign bus.u_valid = (state_q == ST_CMD);
    assign bus.u_addr  = cmd_addr;
    assign bus.u_len   = cmd_len;
    assign bus.u_rw    = cmd_wd ? MEMIF_RD : cmd_rw;
    assign bus.u_wdata = cmd_wd ? '0 : cmd_wdata;

    assign bus.d_ready = ready_vec;
    assign bus.d_wack  = wack_vec;
    assign bus.d_wlast = wlast_vec;
    assign bus.d_rstb  = rstb_vec;
    assign bus.d_rlast = rlast_vec;
    assign bus.d_rdata = {N{bus.u_rdata}};

    // Requesters must hold their command until accepted.
    a_hold_request: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_CMD) |-> bus.d_valid[sel_q]);

endmodule

// File: tb/tb_memif_age_arb.sv
// -----------------------------------------------------------------------------
// tb_memif_age_arb
// Random requesters and a random-latency upstream controller drive the
// arbiter. A transaction-level model (pending requests, wait ages, burst
// progress) predicts each accepted command and each routed beat into
// queues; a monitor compares whenever the DUT shows a handshake.
// -----------------------------------------------------------------------------
module tb_memif_age_arb;
    import memif_pkg::*;

    localparam int unsigned  N       = 3;
    localparam int unsigned  AW      = 32;
    localparam int unsigned  DW      = 16;
    localparam int unsigned  AGE_MAX = 15;
    localparam int unsigned  LW      = MEMIF_LEN_W;
    localparam logic [N-1:0] WD      = 3'b001;

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic          rw;
    } cmd_t;

    typedef struct {
        int            port;
        logic          rd;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    memif_age_arb_if #(.N(N), .AW(AW), .DW(DW)) bus ();

    memif_age_arb #(
        .N             (N),
        .AW            (AW),
        .DW            (DW),
        .WRITE_DISABLE (WD),
        .AGE_MAX       (AGE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    bit    mon_en = 1'b0;

    cmd_t  cmd_q[$];
    beat_t beat_q[$];
    int    quiet_q[$];

    // Reference model state
    bit            pend_v    [N];
    logic [AW-1:0] pend_addr [N];
    logic [LW-1:0] pend_len  [N];
    logic          pend_rw   [N];
    logic [DW-1:0] wdat      [N];
    int            ages      [N];
    int            req_pct   [N] = '{85, 25, 25};
    int            phase       = 0;   // 0 idle, 1 command offered, 2 data
    int            msel        = 0;
    int            beats_left  = 0;
    logic          cur_rd      = 1'b0;
    int            rst_at_beat = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int pick_port();
        for (int i = 0; i < N; i++)
            if (pend_v[i] && ages[i] == AGE_MAX) return i;
        for (int i = 0; i < N; i++)
            if (pend_v[i]) return i;
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < N; i++)
            if (pend_v[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            bus.d_valid[i]             = pend_v[i];
            bus.d_addr[i*AW +: AW]     = pend_addr[i];
            bus.d_len[i*LW +: LW]      = pend_len[i];
            bus.d_rw[i]                = pend_rw[i];
            bus.d_wdata[i*DW +: DW]    = wdat[i];
        end
    endtask

    task automatic drive_cycle(input bit allow_new, input bit quiet);
        int    acc;
        int    p;
        bit    reset_model;
        logic  last;
        cmd_t  c;
        beat_t b;
        acc         = -1;
        reset_model = 1'b0;
        @(negedge clk);
        cyc++;
        rst         = 1'b0;
        bus.u_ready = 1'b0;
        bus.u_wack  = 1'b0;
        bus.u_wlast = 1'b0;
        bus.u_rstb  = 1'b0;
        bus.u_rlast = 1'b0;
        bus.u_rdata = DW'($urandom);
        if (quiet) quiet_q.push_back(cyc);
        for (int i = 0; i < N; i++) begin
            wdat[i] = DW'($urandom);
            if (allow_new && !pend_v[i] && ($urandom_range(99) < req_pct[i])) begin
                pend_v[i]    = 1'b1;
                pend_addr[i] = $urandom;
                pend_len[i]  = ($urandom_range(4) == 0) ? '0 : LW'($urandom_range(3));
                pend_rw[i]   = 1'($urandom_range(1));
            end
        end
        apply_inputs();
        case (phase)
            0: begin
                p = pick_port();
                if (p >= 0) begin
                    msel   = p;
                    c.port = p;
                    c.addr = pend_addr[p];
                    c.len  = pend_len[p];
                    c.rw   = WD[p] ? MEMIF_RD : pend_rw[p];
                    cmd_q.push_back(c);
                    phase  = 1;
                end
            end
            1: begin
                if ($urandom_range(1) == 1) begin
                    bus.u_ready = 1'b1;
                    acc         = msel;
                    beats_left  = int'(pend_len[msel]) + 1;
                    cur_rd      = WD[msel] ? MEMIF_RD : pend_rw[msel];
                    phase       = 2;
                end
            end
            default: begin
                if (rst_at_beat >= 0 || $urandom_range(3) != 0) begin
                    beats_left--;
                    last   = (beats_left == 0);
                    b.port = msel;
                    b.rd   = cur_rd;
                    b.last = last;
                    if (cur_rd) begin
                        bus.u_rstb  = 1'b1;
                        bus.u_rlast = last;
                        b.data      = bus.u_rdata;
                    end else begin
                        bus.u_wack  = 1'b1;
                        bus.u_wlast = last;
                        b.data      = wdat[msel];
                    end
                    beat_q.push_back(b);
                    if (last) phase = 0;
                    if (rst_at_beat >= 0 && beats_left == rst_at_beat) begin
                        rst         = 1'b1;
                        reset_model = 1'b1;
                    end
                end
            end
        endcase
        if (reset_model) begin
            phase       = 0;
            rst_at_beat = -1;
            for (int i = 0; i < N; i++) begin
                pend_v[i] = 1'b0;
                ages[i]   = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i == acc)      ages[i] = 0;
                else if (pend_v[i]) ages[i] = (ages[i] + 1 > AGE_MAX) ? AGE_MAX : ages[i] + 1;
            end
            if (acc >= 0) pend_v[acc] = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && (phase != 0 || any_pending()); k++)
            drive_cycle(1'b0, 1'b0);
    endtask

    // Monitor: compares whenever a command handshake or data beat is visible
    initial begin : monitor
        cmd_t        c;
        beat_t       b;
        logic [N-1:0] onehot, lastvec;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (quiet_q.size() > 0 && quiet_q[0] == cyc) begin
                    void'(quiet_q.pop_front());
                    check("quiet_u_valid", 64'(bus.u_valid), 64'd0);
                    check("quiet_strobes",
                          64'({bus.d_ready, bus.d_wack, bus.d_wlast, bus.d_rstb, bus.d_rlast}), 64'd0);
                end
                if (bus.u_ready) begin
                    check("cmd_expected", 64'(cmd_q.size() != 0), 64'd1);
                    if (cmd_q.size() != 0) begin
                        c = cmd_q.pop_front();
                        onehot = '0;
                        onehot[c.port] = 1'b1;
                        check("u_valid", 64'(bus.u_valid), 64'd1);
                        check("u_addr", 64'(bus.u_addr), 64'(c.addr));
                        check("u_len", 64'(bus.u_len), 64'(c.len));
                        check("u_rw", 64'(bus.u_rw), 64'(c.rw));
                        check("d_ready", 64'(bus.d_ready), 64'(onehot));
                        if (WD[c.port]) check("u_wdata_tied", 64'(bus.u_wdata), 64'd0);
                    end
                end else if (bus.d_ready != '0) begin
                    check("d_ready_spurious", 64'(bus.d_ready), 64'd0);
                end
                if (bus.u_rstb || bus.u_wack || bus.d_rstb != '0 || bus.d_wack != '0) begin
                    check("beat_expected", 64'(beat_q.size() != 0), 64'd1);
                    if (beat_q.size() != 0) begin
                        b = beat_q.pop_front();
                        onehot = '0;
                        onehot[b.port] = 1'b1;
                        lastvec = b.last ? onehot : '0;
                        if (b.rd) begin
                            check("d_rstb", 64'(bus.d_rstb), 64'(onehot));
                            check("d_rlast", 64'(bus.d_rlast), 64'(lastvec));
                            check("d_wack_on_read", 64'(bus.d_wack), 64'd0);
                            check("d_rdata", 64'(bus.d_rdata), 64'({N{b.data}}));
                        end else begin
                            check("d_wack", 64'(bus.d_wack), 64'(onehot));
                            check("d_wlast", 64'(bus.d_wlast), 64'(lastvec));
                            check("d_rstb_on_write", 64'(bus.d_rstb), 64'd0);
                            check("u_wdata", 64'(bus.u_wdata), 64'(b.data));
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < N; i++) begin
            pend_v[i]    = 1'b0;
            pend_addr[i] = '0;
            pend_len[i]  = '0;
            pend_rw[i]   = MEMIF_RD;
            wdat[i]      = '0;
            ages[i]      = 0;
        end
        apply_inputs();
        bus.u_ready = 1'b0;
        bus.u_wack  = 1'b0;
        bus.u_wlast = 1'b0;
        bus.u_rstb  = 1'b0;
        bus.u_rlast = 1'b0;
        bus.u_rdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        mon_en = 1'b1;

        // Released from reset with no requests: everything idle
        drive_cycle(1'b0, 1'b1);

        repeat (2500) drive_cycle(1'b1, 1'b0);
        drain();

        // 8-beat read on port 1, reset during its 2nd beat
        pend_v[1]    = 1'b1;
        pend_addr[1] = 32'h0000_1234;
        pend_len[1]  = LW'(7);
        pend_rw[1]   = MEMIF_RD;
        rst_at_beat  = 6;
        for (int k = 0; k < 40 && rst_at_beat >= 0; k++) drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1);

        repeat (1500) drive_cycle(1'b1, 1'b0);
        drain();
        repeat (2) drive_cycle(1'b0, 1'b0);

        check("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
        check("beat_q_empty", 64'(beat_q.size()), 64'd0);
        check("quiet_q_empty", 64'(quiet_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
